// File: rtl/ln_arbiter_if.sv
// Stream bundle between the two requesters, the shared ln_float32 core and the result consumers.
// The slave modport is the arbiter's view of the bundle; the master modport is the environment's view.
interface ln_arbiter_if;
    logic        s0_tvalid;
    logic        s0_tready;
    logic [31:0] s0_tdata;
    logic        s1_tvalid;
    logic        s1_tready;
    logic [31:0] s1_tdata;
    logic        ln_a_tvalid;
    logic [31:0] ln_a_tdata;
    logic        ln_res_tvalid;
    logic [31:0] ln_res_tdata;
    logic        m0_tvalid;
    logic        m0_tready;
    logic [31:0] m0_tdata;
    logic        m1_tvalid;
    logic        m1_tready;
    logic [31:0] m1_tdata;
    logic        err;

    modport slave (
        input  s0_tvalid, s0_tdata, output s0_tready,
        input  s1_tvalid, s1_tdata, output s1_tready,
        output ln_a_tvalid, ln_a_tdata,
        input  ln_res_tvalid, ln_res_tdata,
        output m0_tvalid, m0_tdata, input m0_tready,
        output m1_tvalid, m1_tdata, input m1_tready,
        output err
    );

    modport master (
        output s0_tvalid, s0_tdata, input s0_tready,
        output s1_tvalid, s1_tdata, input s1_tready,
        input  ln_a_tvalid, ln_a_tdata,
        output ln_res_tvalid, ln_res_tdata,
        input  m0_tvalid, m0_tdata, output m0_tready,
        input  m1_tvalid, m1_tdata, output m1_tready,
        input  err
    );
endinterface

// File: rtl/ln_arbiter.sv
// Round-robin, credit-limited sharing of one ln_float32 core between two requesters with in-order return.
// Define LN_ARBITER_ERRCHK_EN to build the sticky protocol error checker; otherwise err is tied low.
module ln_arbiter #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAGW  = 1
) (
    input logic         aclk,
    input logic         aresetn,
    ln_arbiter_if.slave bus
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned PTRW = PW + 1;
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned DW   = 32;
    localparam int unsigned EW   = TAGW + DW;

    logic [CW-1:0]   credit_q, credit_d;
    logic            rr_q, rr_d;
    logic            run_q;
    logic            ln_a_tvalid_q, ln_a_tvalid_d;
    logic [DW-1:0]   ln_a_tdata_q, ln_a_tdata_d;
    logic [PTRW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PTRW-1:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [TAGW-1:0] tag_mem_q [DEPTH];
    logic [EW-1:0]   res_mem_q [DEPTH];

    logic            issue_ok, gnt, s0_rdy, s1_rdy, issue;
    logic [DW-1:0]   issue_data;
    logic            tag_empty, res_empty, tag_pop, res_push, res_pop;
    logic [TAGW-1:0] tag_head;
    logic [EW-1:0]   res_head;
    logic            m0_vld, m1_vld;

`ifdef LN_ARBITER_ERRCHK_EN
    logic err_q, err_d;
`endif

    // Arbitration, FIFO bookkeeping and credit accounting
    always_comb begin
        issue_ok   = run_q && (credit_q != '0);
        gnt        = (bus.s0_tvalid && bus.s1_tvalid) ? rr_q : bus.s1_tvalid;
        s0_rdy     = issue_ok && bus.s0_tvalid && !gnt;
        s1_rdy     = issue_ok && bus.s1_tvalid && gnt;
        issue      = s0_rdy || s1_rdy;
        issue_data = gnt ? bus.s1_tdata : bus.s0_tdata;

        tag_empty  = (tag_wr_q == tag_rd_q);
        res_empty  = (res_wr_q == res_rd_q);
        tag_head   = tag_mem_q[tag_rd_q[PW-1:0]];
        res_head   = res_mem_q[res_rd_q[PW-1:0]];
        m0_vld     = !res_empty && (res_head[EW-1 -: TAGW] == '0);
        m1_vld     = !res_empty && (res_head[EW-1 -: TAGW] != '0);
        res_pop    = (m0_vld && bus.m0_tready) || (m1_vld && bus.m1_tready);

`ifdef LN_ARBITER_ERRCHK_EN
        err_d      = err_q;
        // A result with no outstanding tag is dropped rather than mis-routed
        tag_pop    = bus.ln_res_tvalid && !tag_empty;
        if (bus.ln_res_tvalid && tag_empty) begin
            err_d = 1'b1;
        end
`else
        tag_pop    = bus.ln_res_tvalid;
`endif
        res_push   = tag_pop;

        rr_d          = issue ? !gnt : rr_q;
        ln_a_tvalid_d = issue;
        ln_a_tdata_d  = issue ? issue_data : ln_a_tdata_q;

        tag_wr_d = issue    ? tag_wr_q + PTRW'(1) : tag_wr_q;
        tag_rd_d = tag_pop  ? tag_rd_q + PTRW'(1) : tag_rd_q;
        res_wr_d = res_push ? res_wr_q + PTRW'(1) : res_wr_q;
        res_rd_d = res_pop  ? res_rd_q + PTRW'(1) : res_rd_q;

        credit_d = credit_q;
        if (issue && !res_pop) begin
            credit_d = credit_q - CW'(1);
        end else if (!issue && res_pop) begin
            credit_d = credit_q + CW'(1);
`ifdef LN_ARBITER_ERRCHK_EN
            if (credit_q == CW'(DEPTH)) begin
                credit_d = credit_q;
                err_d    = 1'b1;
            end
`endif
        end
    end

    // Control state; run_q keeps the requesters stalled while reset is applied
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            credit_q      <= CW'(DEPTH);
            rr_q          <= 1'b0;
            run_q         <= 1'b0;
            ln_a_tvalid_q <= 1'b0;
            ln_a_tdata_q  <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            res_wr_q      <= '0;
            res_rd_q      <= '0;
        end else begin
            credit_q      <= credit_d;
            rr_q          <= rr_d;
            run_q         <= 1'b1;
            ln_a_tvalid_q <= ln_a_tvalid_d;
            ln_a_tdata_q  <= ln_a_tdata_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            res_wr_q      <= res_wr_d;
            res_rd_q      <= res_rd_d;
        end
    end

    // FIFO storage; contents are meaningless until the pointers say otherwise
    always_ff @(posedge aclk) begin
        if (issue) begin
            tag_mem_q[tag_wr_q[PW-1:0]] <= TAGW'(gnt);
        end
        if (res_push) begin
            res_mem_q[res_wr_q[PW-1:0]] <= {tag_head, bus.ln_res_tdata};
        end
    end

`ifdef LN_ARBITER_ERRCHK_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.s0_tready   = s0_rdy;
    assign bus.s1_tready   = s1_rdy;
    assign bus.ln_a_tvalid = ln_a_tvalid_q;
    assign bus.ln_a_tdata  = ln_a_tdata_q;
    assign bus.m0_tvalid   = m0_vld;
    assign bus.m1_tvalid   = m1_vld;
    // Idle outputs read as zero so the reset value holds without clearing storage
    assign bus.m0_tdata    = m0_vld ? res_head[DW-1:0] : '0;
    assign bus.m1_tdata    = m1_vld ? res_head[DW-1:0] : '0;
endmodule

// File: tb/tb_ln_arbiter.sv
// Scoreboard bench for ln_arbiter with a fixed-latency behavioural stand-in for the ln_float32 core.
module tb_ln_arbiter;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 3;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic inj     = 1'b0;

    always #5 aclk = ~aclk;

    ln_arbiter_if bus ();

    ln_arbiter #(.DEPTH(DEPTH), .TAGW(1)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    int          issue_log [$];
    int          n_iss0 = 0;
    int          n_iss1 = 0;
    logic        pend_a = 1'b0;
    logic [31:0] pend_d = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural core: ln(e) = 1.0 exactly; other operands map to a distinct pattern
    function automatic logic [31:0] ln_model(input logic [31:0] x);
        if (x == 32'h402D_F854) return 32'h3F80_0000;
        return ~x;
    endfunction

    logic [LAT-1:0] core_v;
    logic [31:0]    core_d [LAT];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            core_v <= '0;
            for (int i = 0; i < LAT; i++) core_d[i] <= '0;
        end else begin
            core_v    <= {core_v[LAT-2:0], bus.ln_a_tvalid};
            core_d[0] <= ln_model(bus.ln_a_tdata);
            for (int i = 1; i < LAT; i++) core_d[i] <= core_d[i-1];
        end
    end

    assign bus.ln_res_tvalid = core_v[LAT-1] | inj;
    assign bus.ln_res_tdata  = core_d[LAT-1];

    // Monitor: push expectations on accepted operands, compare on presented results
    always @(negedge aclk) begin
        if (!aresetn) begin
            pend_a = 1'b0;
            exp0.delete();
            exp1.delete();
        end else begin
            chk("ln_a_tvalid", 32'(bus.ln_a_tvalid), 32'(pend_a));
            if (pend_a) chk("ln_a_tdata", bus.ln_a_tdata, pend_d);
            pend_a = 1'b0;
            chk("grant", {30'd0, bus.s0_tready & (~bus.s0_tvalid | bus.s1_tready),
                          bus.s1_tready & ~bus.s1_tvalid}, 32'd0);
            if (bus.s0_tvalid && bus.s0_tready) begin
                exp0.push_back(ln_model(bus.s0_tdata));
                issue_log.push_back(0);
                n_iss0++;
                pend_a = 1'b1;
                pend_d = bus.s0_tdata;
            end
            if (bus.s1_tvalid && bus.s1_tready) begin
                exp1.push_back(ln_model(bus.s1_tdata));
                issue_log.push_back(1);
                n_iss1++;
                pend_a = 1'b1;
                pend_d = bus.s1_tdata;
            end
            if (bus.m0_tvalid) begin
                if (exp0.size() == 0) chk("m0_unexpected", 32'd1, 32'd0);
                else begin
                    chk("m0_tdata", bus.m0_tdata, exp0[0]);
                    if (bus.m0_tready) void'(exp0.pop_front());
                end
            end
            if (bus.m1_tvalid) begin
                if (exp1.size() == 0) chk("m1_unexpected", 32'd1, 32'd0);
                else begin
                    chk("m1_tdata", bus.m1_tdata, exp1[0]);
                    if (bus.m1_tready) void'(exp1.pop_front());
                end
            end
        end
    end

    task automatic set_src(input int id, input logic v, input logic [31:0] d);
        if (id == 0) begin
            bus.s0_tvalid = v;
            bus.s0_tdata  = d;
        end else begin
            bus.s1_tvalid = v;
            bus.s1_tdata  = d;
        end
    endtask

    task automatic send(input int id, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            logic hs;
            int   cyc;
            set_src(id, 1'b1, base + 32'(i) * 32'h0001_0003);
            hs  = 1'b0;
            cyc = 0;
            while (!hs && cyc < 2000) begin
                @(negedge aclk);
                hs = (id == 0) ? bus.s0_tready : bus.s1_tready;
                @(posedge aclk);
                #1;
                cyc++;
            end
            if (!hs) chk("send_timeout", 32'd0, 32'd1);
        end
        set_src(id, 1'b0, '0);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp0.size() + exp1.size()) != 0 && c < 500) begin
            @(negedge aclk);
            c++;
        end
        chk("drained", 32'(exp0.size() + exp1.size()), 32'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        bus.s0_tvalid = 1'b1;
        bus.s0_tdata  = 32'h1234_5678;
        bus.s1_tvalid = 1'b1;
        bus.s1_tdata  = 32'h8765_4321;
        bus.m0_tready = 1'b1;
        bus.m1_tready = 1'b1;

        // Reset values with requesters pushing
        @(negedge aclk);
        chk("rst_ln_a_tvalid", 32'(bus.ln_a_tvalid), 32'd0);
        chk("rst_ln_a_tdata",  bus.ln_a_tdata, 32'd0);
        chk("rst_s0_tready",   32'(bus.s0_tready), 32'd0);
        chk("rst_s1_tready",   32'(bus.s1_tready), 32'd0);
        chk("rst_m0_tvalid",   32'(bus.m0_tvalid), 32'd0);
        chk("rst_m1_tvalid",   32'(bus.m1_tvalid), 32'd0);
        chk("rst_m0_tdata",    bus.m0_tdata, 32'd0);
        chk("rst_m1_tdata",    bus.m1_tdata, 32'd0);
        chk("rst_err",         32'(bus.err), 32'd0);
        set_src(0, 1'b0, '0);
        set_src(1, 1'b0, '0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Single request: ln(e) returns 1.0 on m0
        send(0, 1, 32'h402D_F854);
        c = 0;
        while (!bus.m0_tvalid && c < 50) begin
            @(negedge aclk);
            c++;
        end
        chk("ln_e_result", bus.m0_tdata, 32'h3F80_0000);
        wait_drain();

        // Both requesters continuously valid: strict alternation starting at 0
        do_reset();
        issue_log.delete();
        fork
            send(0, 8, 32'h3F00_0000);
            send(1, 8, 32'h4100_0000);
        join
        wait_drain();
        chk("rr_count", 32'(issue_log.size()), 32'd16);
        for (int i = 0; i < issue_log.size(); i++) chk("rr_order", 32'(issue_log[i]), 32'(i % 2));

        // Credit exhaustion with blocked consumer, then drain
        do_reset();
        bus.m0_tready = 1'b0;
        n_iss0 = 0;
        fork
            send(0, 20, 32'h4200_0000);
            begin
                repeat (60) @(negedge aclk);
                chk("fill_count", 32'(n_iss0), 32'(DEPTH));
                chk("fill_s0_tready", 32'(bus.s0_tready), 32'd0);
                @(posedge aclk);
                #1;
                bus.m0_tready = 1'b1;
            end
        join
        wait_drain();
        chk("fill_total", 32'(n_iss0), 32'd20);

        // Head-of-line blocking behind a stalled requester-1 result
        do_reset();
        bus.m0_tready = 1'b1;
        bus.m1_tready = 1'b0;
        send(1, 1, 32'h4300_0000);
        send(0, 2, 32'h4400_0000);
        repeat (10) @(negedge aclk);
        chk("hol_m0_tvalid", 32'(bus.m0_tvalid), 32'd0);
        chk("hol_m1_tvalid", 32'(bus.m1_tvalid), 32'd1);
        chk("hol_q0", 32'(exp0.size()), 32'd2);
        @(posedge aclk);
        #1;
        bus.m1_tready = 1'b1;
        wait_drain();

        // Reset with results in flight, then full credit and clean completion
        do_reset();
        bus.m0_tready = 1'b0;
        send(0, 5, 32'h4500_0000);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mid_rst_ln_a_tvalid", 32'(bus.ln_a_tvalid), 32'd0);
        chk("mid_rst_ln_a_tdata",  bus.ln_a_tdata, 32'd0);
        chk("mid_rst_m0_tvalid",   32'(bus.m0_tvalid), 32'd0);
        chk("mid_rst_m0_tdata",    bus.m0_tdata, 32'd0);
        chk("mid_rst_m1_tvalid",   32'(bus.m1_tvalid), 32'd0);
        chk("mid_rst_s0_tready",   32'(bus.s0_tready), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        n_iss0 = 0;
        fork
            send(0, 17, 32'h4600_0000);
            begin
                repeat (60) @(negedge aclk);
                chk("post_rst_credit", 32'(n_iss0), 32'(DEPTH));
                @(posedge aclk);
                #1;
                bus.m0_tready = 1'b1;
            end
        join
        wait_drain();
        chk("post_rst_total", 32'(n_iss0), 32'd17);

`ifdef LN_ARBITER_ERRCHK_EN
        // Spurious core result: sticky err, nothing delivered
        do_reset();
        chk("err_before", 32'(bus.err), 32'd0);
        @(posedge aclk);
        #1;
        inj = 1'b1;
        @(posedge aclk);
        #1;
        inj = 1'b0;
        @(negedge aclk);
        chk("err_set", 32'(bus.err), 32'd1);
        repeat (5) @(negedge aclk);
        chk("err_sticky", 32'(bus.err), 32'd1);
        chk("err_m0_tvalid", 32'(bus.m0_tvalid), 32'd0);
        chk("err_m1_tvalid", 32'(bus.m1_tvalid), 32'd0);
`else
        chk("err_tied_low", 32'(bus.err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
